// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port-A arbiter: master ids, lock owner and the arbiter state.
package ram_port_arbiter_pkg;

  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_owner_t;

  // Complete arbiter state, kept as one struct so checkers can bind to a single signal.
  typedef struct packed {
    logic        rr_ptr;
    lock_owner_t lock_owner;
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with bus lock; owns rr_ptr and lock_owner.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  arb_state_t state;
  arb_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state.rr_ptr     <= MASTER_M0;
      state.lock_owner <= LOCK_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // A transfer hands priority to the other master and sets or clears the lock.
  always_comb begin
    state_nxt = state;
    if (gnt[0]) begin
      state_nxt.rr_ptr     = MASTER_M1;
      state_nxt.lock_owner = lock[0] ? LOCK_M0 : LOCK_NONE;
    end else if (gnt[1]) begin
      state_nxt.rr_ptr     = MASTER_M0;
      state_nxt.lock_owner = lock[1] ? LOCK_M1 : LOCK_NONE;
    end
  end

  // A locked owner that stops requesting keeps the bus idle rather than releasing it.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (state.lock_owner)
        LOCK_M0: gnt[0] = req[0];
        LOCK_M1: gnt[1] = req[1];
        default: begin
          if (req[0] && req[1]) begin
            gnt = (state.rr_ptr == MASTER_M1) ? 2'b10 : 2'b01;
          end else begin
            gnt = req;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between the CPU (m0) and the time-keeping engine (m1), one access per cycle.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_req,
  input  logic                     m0_lock,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr,
  input  logic [3:0]               m0_wstrb,
  input  logic [31:0]              m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [31:0]              m0_rdata,
  input  logic                     m1_req,
  input  logic                     m1_lock,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr,
  input  logic [3:0]               m1_wstrb,
  input  logic [31:0]              m1_wdata,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [31:0]              m1_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_addra,
  output logic                     ram_rena,
  output logic                     ram_wena,
  output logic [3:0]               ram_wstrba,
  output logic [31:0]              ram_dina,
  input  logic [31:0]              ram_douta
);

  // Handshake: an access transfers in any cycle with req=1 and gnt=1; the master holds
  // addr/we/wstrb/wdata stable while req=1, and reads answer with rvalid exactly one cycle later.

  logic [1:0] gnt;
  logic       sel;
  logic       sel_we;
  logic       rd_valid_q;
  logic       rd_tag_q;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({m1_req, m0_req}),
    .lock ({m1_lock, m0_lock}),
    .gnt  (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  assign sel    = gnt[1] ? MASTER_M1 : MASTER_M0;

  always_comb begin
    if (sel == MASTER_M1) begin
      ram_addra  = m1_addr;
      ram_dina   = m1_wdata;
      ram_wstrba = m1_wstrb;
      sel_we     = m1_we;
    end else begin
      ram_addra  = m0_addr;
      ram_dina   = m0_wdata;
      ram_wstrba = m0_wstrb;
      sel_we     = m0_we;
    end
  end

  assign ram_rena = (|gnt) & ~sel_we;
  assign ram_wena = (|gnt) & sel_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= MASTER_M0;
    end else begin
      rd_valid_q <= ram_rena;
      rd_tag_q   <= sel;
    end
  end

  // Gating with rst drops a read that was in flight when reset arrived.
  assign m0_rvalid = rd_valid_q & (rd_tag_q == MASTER_M0) & ~rst;
  assign m1_rvalid = rd_valid_q & (rd_tag_q == MASTER_M1) & ~rst;
  assign m0_rdata  = m0_rvalid ? ram_douta : 32'h0;
  assign m1_rdata  = m1_rvalid ? ram_douta : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks of ram_port_arbiter against a behavioural 8-word RAM.
module tb_ram_port_arbiter;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_wstrb;
  logic [31:0]   m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_wstrb;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [AW-1:0] ram_addra;
  logic          ram_rena, ram_wena;
  logic [3:0]    ram_wstrba;
  logic [31:0]   ram_dina, ram_douta;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [8];
  logic [31:0] shadow [8];
  logic [31:0] exp_q[$];
  logic        exp_tag_q[$];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addra(ram_addra), .ram_rena(ram_rena), .ram_wena(ram_wena),
    .ram_wstrba(ram_wstrba), .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  // Port-A RAM: byte-strobed write and registered read on the same edge.
  always @(posedge clk) begin
    if (ram_wena) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrba[b]) mem[ram_addra[4:2]][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    if (ram_rena) ram_douta <= mem[ram_addra[4:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [3:0] strb, input logic [31:0] data);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wstrb = strb; m0_wdata = data;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wstrb = strb; m1_wdata = data;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    drive(0, 1, 0, 0, 5'h04, 4'h0, 32'h0);
    drive(1, 1, 0, 0, 5'h08, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (m0_gnt !== 1'b0) begin bad++; $display("FAIL reset_m0_gnt got=%b want=0", m0_gnt); end
    total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL reset_m1_gnt got=%b want=0", m1_gnt); end
    total++; if ({ram_rena, ram_wena} !== 2'b00) begin bad++; $display("FAIL reset_ram_en got=%b%b want=00", ram_rena, ram_wena); end
    step();
    @(negedge clk);
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b%b want=00", m0_rvalid, m1_rvalid); end
    step();
    rst = 0;
    idle();
  endtask

  task automatic test_single_read();
    drive(0, 1, 0, 0, 5'h04, 4'h0, 32'h0);
    @(negedge clk);
    total++; if ({m1_gnt, m0_gnt} !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b%b want=01", m1_gnt, m0_gnt); end
    total++; if (ram_rena !== 1'b1 || ram_wena !== 1'b0) begin bad++; $display("FAIL single_ren got=%b%b want=10", ram_rena, ram_wena); end
    total++; if (ram_addra !== 5'h04) begin bad++; $display("FAIL single_addr got=%h want=04", ram_addra); end
    step();
    idle();
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL single_rvalid got=%b want=1", m0_rvalid); end
    total++; if (m0_rdata !== 32'hC0DE0001) begin bad++; $display("FAIL single_rdata got=%h want=c0de0001", m0_rdata); end
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL single_m1_rvalid got=%b want=0", m1_rvalid); end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp0;
    do_reset();
    drive(0, 1, 0, 0, 5'h00, 4'h0, 32'h0);
    drive(1, 1, 0, 0, 5'h0C, 4'h0, 32'h0);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      exp0 = (i % 2 == 0) && (i < 6);
      total++;
      if (m0_gnt !== exp0 || m1_gnt !== ((i < 6) && !exp0)) begin
        bad++; $display("FAIL b2b_gnt cycle=%0d got=%b%b want=%b%b", i, m1_gnt, m0_gnt, (i < 6) && !exp0, exp0);
      end
      if (i > 0 && ((i - 1) % 2 == 0)) begin
        total++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hC0DE0000) begin
          bad++; $display("FAIL b2b_m0_ret cycle=%0d got=%b%b/%h want=10/c0de0000", i, m0_rvalid, m1_rvalid, m0_rdata);
        end
      end else if (i > 0) begin
        total++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hC0DE0003) begin
          bad++; $display("FAIL b2b_m1_ret cycle=%0d got=%b%b/%h want=01/c0de0003", i, m0_rvalid, m1_rvalid, m1_rdata);
        end
      end
      step();
      if (i == 5) idle();
    end
  endtask

  task automatic test_write_then_read();
    drive(1, 1, 1, 0, 5'h08, 4'b0011, 32'hDEADBEEF);
    @(negedge clk);
    total++; if ({m1_gnt, m0_gnt} !== 2'b10) begin bad++; $display("FAIL wr_gnt got=%b%b want=10", m1_gnt, m0_gnt); end
    total++; if ({ram_wena, ram_rena} !== 2'b10) begin bad++; $display("FAIL wr_en got=%b%b want=10", ram_wena, ram_rena); end
    total++; if (ram_dina !== 32'hDEADBEEF || ram_wstrba !== 4'b0011 || ram_addra !== 5'h08) begin
      bad++; $display("FAIL wr_drive got=%h/%b/%h want=deadbeef/0011/08", ram_dina, ram_wstrba, ram_addra);
    end
    step();
    idle();
    drive(0, 1, 0, 0, 5'h08, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL wr_rd_gnt got=%b want=1", m0_gnt); end
    total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_resp got=%b want=0", m1_rvalid); end
    step();
    idle();
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DEBEEF) begin
      bad++; $display("FAIL wr_rd_data got=%b/%h want=1/c0debeef", m0_rvalid, m0_rdata);
    end
    shadow[2] = 32'hC0DEBEEF;
    step();
  endtask

  task automatic test_lock();
    logic [5:0] r0, l0, g0, g1;
    r0 = 6'b111011; l0 = 6'b001011; g0 = 6'b011011; g1 = 6'b100000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, r0[i], 0, l0[i], 5'h00, 4'h0, 32'h0);
      drive(1, 1, 0, 0, 5'h10, 4'h0, 32'h0);
      @(negedge clk);
      total++; if (m0_gnt !== g0[i] || m1_gnt !== g1[i]) begin
        bad++; $display("FAIL lock_gnt cycle=%0d got=%b%b want=%b%b", i, m1_gnt, m0_gnt, g1[i], g0[i]);
      end
      step();
    end
    idle();
    @(negedge clk);
    total++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hC0DE0004) begin
      bad++; $display("FAIL lock_m1_ret got=%b%b/%h want=01/c0de0004", m0_rvalid, m1_rvalid, m1_rdata);
    end
    step();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    drive(0, 1, 0, 1, 5'h04, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL rstf_gnt got=%b want=1", m0_gnt); end
    step();
    rst = 1;
    idle();
    drive(1, 1, 0, 0, 5'h0C, 4'h0, 32'h0);
    @(negedge clk);
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL rstf_rvalid got=%b want=0", m0_rvalid); end
    total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL rstf_gnt_drop got=%b want=0", m1_gnt); end
    step();
    rst = 0;
    @(negedge clk);
    total++; if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin
      bad++; $display("FAIL rstf_lock_clear got=gnt%b/rv%b want=gnt1/rv0", m1_gnt, m0_rvalid);
    end
    step();
    idle();
    @(negedge clk);
    total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hC0DE0003) begin
      bad++; $display("FAIL rstf_m1_ret got=%b/%h want=1/c0de0003", m1_rvalid, m1_rdata);
    end
    step();
    drive(0, 1, 0, 0, 5'h00, 4'h0, 32'h0);
    step();
    rst = 1;
    idle();
    step();
    rst = 0;
    drive(0, 1, 0, 0, 5'h00, 4'h0, 32'h0);
    drive(1, 1, 0, 0, 5'h0C, 4'h0, 32'h0);
    @(negedge clk);
    total++; if ({m1_gnt, m0_gnt} !== 2'b01) begin bad++; $display("FAIL rstf_ptr got=%b%b want=01", m1_gnt, m0_gnt); end
    step();
    idle();
    step();
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic        hold0, hold1, m_ptr, g0, g1, we, lk, t;
    logic [1:0]  m_lock;
    logic [4:0]  addr;
    logic [3:0]  strb;
    logic [31:0] data, d;
    do_reset();
    hold0 = 0; hold1 = 0; m_ptr = 0; m_lock = 2'd0;
    for (int i = 0; i <= N; i++) begin
      if (i == N) idle();
      else begin
        if (!hold0)
          drive(0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                5'($urandom_range(0, 7)) << 2, 4'($urandom_range(0, 15)), $urandom);
        if (!hold1)
          drive(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                5'($urandom_range(0, 7)) << 2, 4'($urandom_range(0, 15)), $urandom);
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        t = exp_tag_q.pop_front();
        total++; if (m0_rvalid !== !t || m1_rvalid !== t || (t ? m1_rdata : m0_rdata) !== d) begin
          bad++; $display("FAIL rnd_ret cycle=%0d got=%b%b/%h/%h want_tag=%b data=%h", i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, t, d);
        end
      end else begin
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
          bad++; $display("FAIL rnd_spurious_rvalid cycle=%0d got=%b%b want=00", i, m0_rvalid, m1_rvalid);
        end
      end
      g0 = 0; g1 = 0;
      if (m_lock == 2'd1) g0 = m0_req;
      else if (m_lock == 2'd2) g1 = m1_req;
      else if (m0_req && m1_req) begin
        if (m_ptr) g1 = 1; else g0 = 1;
      end else begin
        g0 = m0_req; g1 = m1_req;
      end
      total++; if (m0_gnt !== g0 || m1_gnt !== g1) begin
        bad++; $display("FAIL rnd_gnt cycle=%0d got=%b%b want=%b%b", i, m1_gnt, m0_gnt, g1, g0);
      end
      total++; if ((ram_rena & ram_wena) !== 1'b0) begin
        bad++; $display("FAIL rnd_ren_wen cycle=%0d got=%b%b want=not both", i, ram_rena, ram_wena);
      end
      if (g0 || g1) begin
        we   = g1 ? m1_we : m0_we;
        lk   = g1 ? m1_lock : m0_lock;
        addr = g1 ? m1_addr : m0_addr;
        strb = g1 ? m1_wstrb : m0_wstrb;
        data = g1 ? m1_wdata : m0_wdata;
        total++; if ({ram_wena, ram_rena} !== {we, !we} || ram_addra !== addr) begin
          bad++; $display("FAIL rnd_drive cycle=%0d got=%b%b/%h want=%b%b/%h", i, ram_wena, ram_rena, ram_addra, we, !we, addr);
        end
        if (!we) begin
          exp_q.push_back(shadow[addr[4:2]]);
          exp_tag_q.push_back(g1);
        end else begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) shadow[addr[4:2]][8*b +: 8] = data[8*b +: 8];
        end
        m_ptr  = g0;
        m_lock = lk ? (g1 ? 2'd2 : 2'd1) : 2'd0;
      end else begin
        total++; if ({ram_wena, ram_rena} !== 2'b00) begin
          bad++; $display("FAIL rnd_idle_en cycle=%0d got=%b%b want=00", i, ram_wena, ram_rena);
        end
      end
      hold0 = m0_req && !g0;
      hold1 = m1_req && !g1;
      step();
    end
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_unreturned got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    for (int w = 0; w < 8; w++) begin
      mem[w]    = 32'hC0DE0000 + 32'(w);
      shadow[w] = 32'hC0DE0000 + 32'(w);
    end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_then_read();
    test_lock();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
